// File: rtl/mul_fp_seq.sv
// Sequential signed fixed-point multiplier.
// The responder end of the io_start/io_done multiply handshake.
// The multiplier works on operand magnitudes with shift-add, one multiplier
// bit per cycle. It then truncates the product toward zero, checks for
// overflow and re-applies the sign.
// Latency is fixed: io_done is high in the cycle after start edge + WIDTH + 1.
module mul_fp_seq #(
    parameter int WIDTH = 25,
    parameter int FBITS = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             io_start,
    output logic             io_busy,
    output logic             io_done,
    output logic             io_valid,
    output logic             io_ovf,
    input  logic [WIDTH-1:0] io_a,
    input  logic [WIDTH-1:0] io_b,
    output logic [WIDTH-1:0] io_val
);

    localparam int CW = $clog2(WIDTH);
    // Width of the product after the fractional bits are dropped.
    localparam int RW = 2*WIDTH - FBITS;

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_sign;
    logic [2*WIDTH-1:0]  r_a_sh;     // |a|, shifted left once per CALC cycle
    logic [WIDTH-1:0]    r_b;        // |b|, shifted right once per CALC cycle
    logic [2*WIDTH-1:0]  r_acc;
    logic [CW-1:0]       r_cnt;
    logic                r_busy;
    logic                r_done;
    logic                r_valid;
    logic                r_ovf;
    logic [WIDTH-1:0]    r_val;

    logic [WIDTH-1:0]    w_abs_a;
    logic [WIDTH-1:0]    w_abs_b;
    logic [RW-1:0]       w_r;
    logic [WIDTH-1:0]    w_mag;
    logic                w_ovf;
    logic [WIDTH-1:0]    w_res;

    // Operand magnitudes. Negating -2^(W-1) gives back the same bit pattern.
    // Read as unsigned, that pattern is exactly 2^(W-1).
    assign w_abs_a = io_a[WIDTH-1] ? -io_a : io_a;
    assign w_abs_b = io_b[WIDTH-1] ? -io_b : io_b;

    // Truncate the magnitude (round toward zero).
    // A magnitude of 2^(W-1) or more does not fit, not even as the most negative value.
    assign w_r   = r_acc[2*WIDTH-1:FBITS];
    assign w_ovf = |w_r[RW-1:WIDTH-1];
    assign w_mag = w_r[WIDTH-1:0];
    assign w_res = r_sign ? -w_mag : w_mag;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) assignments only. The
    // asynchronous active-low reset is in the sensitivity list, so reset
    // takes effect at once and does not wait for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic.
    // NOTE: w_next gets a default before the case statement. Every path then
    // assigns it, so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (io_start) w_next = CALC;
            CALC:    if (r_cnt == CW'(WIDTH-1)) w_next = SIGN;
            SIGN:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath and registered outputs.
    // The done, valid and ovf flags are pulses: they clear every cycle unless SIGN sets them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign  <= 1'b0;
            r_a_sh  <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_val   <= '0;
        end else begin
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (io_start) begin
                        r_sign <= io_a[WIDTH-1] ^ io_b[WIDTH-1];
                        r_a_sh <= {{WIDTH{1'b0}}, w_abs_a};
                        r_b    <= w_abs_b;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                    end
                end
                CALC: begin
                    if (r_b[0]) r_acc <= r_acc + r_a_sh;
                    r_a_sh <= r_a_sh << 1;
                    r_b    <= r_b >> 1;
                    r_cnt  <= r_cnt + CW'(1);
                end
                SIGN: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    if (w_ovf) begin
                        r_ovf <= 1'b1;
                        r_val <= '0;
                    end else begin
                        r_valid <= 1'b1;
                        r_val   <= w_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_busy  = r_busy;
    assign io_done  = r_done;
    assign io_valid = r_valid;
    assign io_ovf   = r_ovf;
    assign io_val   = r_val;

endmodule

// File: tb/tb_mul_fp_seq.sv
// Self-checking bench for mul_fp_seq.
// Expected results go into a scoreboard queue when an operation is launched.
// They are popped and compared when io_done is seen.
module tb_mul_fp_seq;

    localparam int WIDTH = 25;
    localparam int FBITS = 21;
    localparam int LAT   = WIDTH + 1;

    typedef struct packed {
        logic [WIDTH-1:0] val;
        logic             valid;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             io_start;
    logic             io_busy;
    logic             io_done;
    logic             io_valid;
    logic             io_ovf;
    logic [WIDTH-1:0] io_a;
    logic [WIDTH-1:0] io_b;
    logic [WIDTH-1:0] io_val;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mul_fp_seq #(.WIDTH(WIDTH), .FBITS(FBITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .io_start (io_start),
        .io_busy  (io_busy),
        .io_done  (io_done),
        .io_valid (io_valid),
        .io_ovf   (io_ovf),
        .io_a     (io_a),
        .io_b     (io_b),
        .io_val   (io_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. It uses the full signed product and truncates the magnitude toward zero.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        longint pa, pb, p, mag, r, lim;
        exp_t   e;
        pa  = longint'($signed(a));
        pb  = longint'($signed(b));
        p   = pa * pb;
        mag = (p < 0) ? -p : p;
        r   = mag >> FBITS;
        lim = longint'(1) << (WIDTH-1);
        if (r >= lim) begin
            e.val = '0; e.valid = 1'b0; e.ovf = 1'b1;
        end else begin
            e.val = WIDTH'((p < 0) ? -r : r); e.valid = 1'b1; e.ovf = 1'b0;
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic [WIDTH-1:0] v, input logic vld, input logic o);
        exp_t e;
        e.val = v; e.valid = vld; e.ovf = o;
        return e;
    endfunction

    // Crosses the start edge: start is already high, so this posedge samples it.
    // The operands are then scrambled.
    task automatic fire();
        @(posedge clk);
        #1;
        io_start = 1'b0;
        io_a     = WIDTH'($urandom);
        io_b     = WIDTH'($urandom);
    endtask

    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input exp_t e, input bit push);
        @(negedge clk);
        if (push) sb.push_back(e);
        io_a     = a;
        io_b     = b;
        io_start = 1'b1;
        fire();
    endtask

    // Waits a bounded time for io_done and checks latency, busy and the scoreboard result.
    // poke_at > 0 re-asserts start with junk operands in that cycle.
    // chain = 1 drives the next operation in the io_done cycle.
    task automatic wait_done(input int poke_at, input bit chain,
                             input logic [WIDTH-1:0] ca, input logic [WIDTH-1:0] cb);
        int   n = 0;
        bit   seen = 0;
        exp_t e;
        logic [WIDTH-1:0] held;
        while (!seen && n < LAT + 10) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == poke_at) begin
                io_start = 1'b1;
                io_a     = WIDTH'($urandom);
                io_b     = WIDTH'($urandom);
            end else if (poke_at > 0 && n == poke_at + 1) begin
                io_start = 1'b0;
            end
            if (n == 1 || n == LAT - 1) begin
                checks++;
                if (io_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_during_op cycle %0d: got %b want 1", n, io_busy);
                end
            end
            if (io_done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: no io_done within %0d cycles", n);
            return;
        end
        if (n !== LAT) begin
            errors++;
            $display("FAIL latency: got %0d want %0d", n, LAT);
        end
        checks++;
        if (io_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done: got %b want 0", io_busy);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: unexpected io_done val=%h", io_val);
        end else begin
            e = sb.pop_front();
            if ({io_val, io_valid, io_ovf} !== {e.val, e.valid, e.ovf}) begin
                errors++;
                $display("FAIL result: got val=%h valid=%b ovf=%b want val=%h valid=%b ovf=%b",
                         io_val, io_valid, io_ovf, e.val, e.valid, e.ovf);
            end
        end
        held = io_val;
        if (chain) begin
            sb.push_back(model(ca, cb));
            io_a     = ca;
            io_b     = cb;
            io_start = 1'b1;
        end else begin
            @(negedge clk);
            checks++;
            if ({io_done, io_valid, io_ovf, io_val} !== {3'b000, held}) begin
                errors++;
                $display("FAIL pulse_width: got done=%b valid=%b ovf=%b val=%h want 000 val=%h",
                         io_done, io_valid, io_ovf, io_val, held);
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        io_start = 1'b0;
        io_a     = '0;
        io_b     = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({io_busy, io_done, io_valid, io_ovf, io_val} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b valid=%b ovf=%b val=%h want all 0",
                     io_busy, io_done, io_valid, io_ovf, io_val);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        launch(25'h0300000, 25'h0400000, mk(25'h0600000, 1'b1, 1'b0), 1);
        wait_done(0, 0, '0, '0);
    endtask

    task automatic test_sign();
        launch(25'h1D00000, 25'h0400000, mk(25'h1A00000, 1'b1, 1'b0), 1);
        wait_done(0, 0, '0, '0);
        launch(25'h1E00000, 25'h1E00000, mk(25'h0200000, 1'b1, 1'b0), 1);
        wait_done(0, 0, '0, '0);
    endtask

    task automatic test_trunc();
        launch(25'h0000001, 25'h0100000, mk(25'h0, 1'b1, 1'b0), 1);
        wait_done(0, 0, '0, '0);
        launch(25'h1FFFFFF, 25'h0100000, mk(25'h0, 1'b1, 1'b0), 1);
        wait_done(0, 0, '0, '0);
    endtask

    task automatic test_ovf();
        launch(25'h0800000, 25'h0800000, mk(25'h0, 1'b0, 1'b1), 1);
        wait_done(0, 0, '0, '0);
        launch(25'h1000000, 25'h1E00000, mk(25'h0, 1'b0, 1'b1), 1);
        wait_done(0, 0, '0, '0);
    endtask

    task automatic test_ignore_start();
        launch(25'h0300000, 25'h1D00000, model(25'h0300000, 25'h1D00000), 1);
        wait_done(8, 0, '0, '0);
        // A re-sampled start would create a second io_done here.
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            if (io_done === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL extra_done: got io_done=1 want 0 at cycle %0d", i);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        launch(25'h0280000, 25'h0600000, model(25'h0280000, 25'h0600000), 1);
        wait_done(0, 1, 25'h1C40000, 25'h0340000);
        fire();
        wait_done(0, 0, '0, '0);
    endtask

    task automatic test_async_reset();
        launch(25'h0300000, 25'h0400000, mk('0, 1'b0, 1'b0), 0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        checks++;
        if (io_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_before_reset: got %b want 1", io_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({io_busy, io_done, io_valid, io_ovf, io_val} !== '0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b valid=%b ovf=%b val=%h want all 0",
                     io_busy, io_done, io_valid, io_ovf, io_val);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        for (int i = 0; i < LAT + 6; i++) begin
            @(negedge clk);
            if (io_done === 1'b1 || io_busy === 1'b1) begin
                errors++;
                $display("FAIL abandoned_op: got done=%b busy=%b want 0 0", io_done, io_busy);
                break;
            end
        end
        launch(25'h1D00000, 25'h0400000, mk(25'h1A00000, 1'b1, 1'b0), 1);
        wait_done(0, 0, '0, '0);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b;
        for (int i = 0; i < 6; i++) begin
            a = WIDTH'($signed(WIDTH'($urandom)) >>> $urandom_range(0, 5));
            b = WIDTH'($signed(WIDTH'($urandom)) >>> $urandom_range(0, 5));
            launch(a, b, model(a, b), 1);
            wait_done(0, 0, '0, '0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_async_reset();
        test_sign();
        test_trunc();
        test_ovf();
        test_ignore_start();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
